// File: rtl/nand_test_sequencer_pkg.sv
// Shared definitions for the quad-NAND test sequencer: FSM state encoding,
// gate count, field widths and the per-gate vector-code function.
package nand_test_sequencer_pkg;

  localparam int unsigned NUM_GATES = 4;
  localparam int unsigned VEC_W     = 2;                      // vector index / code width
  localparam int unsigned CNT_W     = 8;                      // fail_count width
  localparam int unsigned PASS_W    = 4;                      // pass counter width
  localparam int unsigned TIMER_W   = 4;                      // settle timer width
  localparam int unsigned MIS_W     = $clog2(NUM_GATES + 1);  // per-check mismatch tally

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  // Input code for gate g on vector v: c = (v + g) mod 4, a = c[1], b = c[0].
  function automatic logic [VEC_W-1:0] vec_code(input logic [VEC_W-1:0] v,
                                                input logic [VEC_W-1:0] g);
    return v + g;
  endfunction

endpackage

// File: rtl/nand_test_sequencer_if.sv
// Bus between the sequencer and its surroundings: run control, status and
// the A/B drive plus Y sense lines of the quad-NAND under test.
//   slave  : the sequencer (takes start/abort/y_in, drives everything else)
//   master : the controlling host / gate model
interface nand_test_sequencer_if;

  logic                                          start;
  logic                                          abort;
  logic [nand_test_sequencer_pkg::NUM_GATES-1:0] a_drv;
  logic [nand_test_sequencer_pkg::NUM_GATES-1:0] b_drv;
  logic [nand_test_sequencer_pkg::NUM_GATES-1:0] y_in;
  logic                                          busy;
  logic                                          done;
  logic                                          pass;
  logic [nand_test_sequencer_pkg::NUM_GATES-1:0] fail_mask;
  logic [nand_test_sequencer_pkg::CNT_W-1:0]     fail_count;
  logic [nand_test_sequencer_pkg::VEC_W-1:0]     vec_idx;

  modport slave (
    input  start, abort, y_in,
    output a_drv, b_drv, busy, done, pass, fail_mask, fail_count, vec_idx
  );

  modport master (
    output start, abort, y_in,
    input  a_drv, b_drv, busy, done, pass, fail_mask, fail_count, vec_idx
  );

endinterface

// File: rtl/nand_test_sequencer_settle_timer.sv
// Settle wait counter: load a value, count down to zero, hold at zero.
//   clk, rst  : clock and synchronous active-high reset
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : cycles remaining after the load edge
//   zero_c    : counter is at zero (combinational from the count flop)
module nand_test_sequencer_settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/nand_test_sequencer.sv
// Quad-NAND test sequencer. Sweeps the four input codes over all gates
// NUM_PASSES times, waits SETTLE_CYCLES after each drive, checks the Y
// outputs and accumulates sticky per-gate failures and a saturating count.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : start/abort control, a_drv/b_drv/y_in gate lines,
//              busy/done/pass/fail_mask/fail_count/vec_idx status
// Status outputs are registered images of the state one cycle back, so done
// rises the edge after FINISH is entered and busy falls one cycle after done.
// abort bypasses that delay so busy and drives drop on the abort edge.
module nand_test_sequencer
  import nand_test_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 1
) (
  input logic                  CLK,
  input logic                  RST,
  nand_test_sequencer_if.slave bus
);

  localparam int unsigned SUM_W       = CNT_W + 1;
  localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  state_t               state_q, state_d;
  state_t               out_state_c;
  logic [VEC_W-1:0]     v_q, v_d;
  logic [PASS_W-1:0]    pass_cnt_q, pass_cnt_d;
  logic [NUM_GATES-1:0] fail_mask_q, fail_mask_d;
  logic [CNT_W-1:0]     fail_count_q, fail_count_d;
  logic [NUM_GATES-1:0] a_drv_q, a_drv_d;
  logic [NUM_GATES-1:0] b_drv_q, b_drv_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [VEC_W-1:0]     vec_idx_q, vec_idx_d;

  logic [NUM_GATES-1:0] mismatch_c;
  logic [MIS_W-1:0]     n_mis_c;
  logic [SUM_W-1:0]     sum_c;
  logic [CNT_W-1:0]     fail_count_sat_c;
  logic [VEC_W-1:0]     code_c;
  logic                 timer_load_c;
  logic                 timer_zero_c;

  nand_test_sequencer_settle_timer #(
    .W (TIMER_W)
  ) u_settle_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (timer_load_c),
    .load_val (TIMER_W'(SETTLE_LOAD)),
    .zero_c   (timer_zero_c)
  );

  // Per-gate check; case inequality so X/Z on y_in is a failure.
  always_comb begin
    mismatch_c = '0;
    n_mis_c    = '0;
    for (int g = 0; g < int'(NUM_GATES); g++) begin
      mismatch_c[g] = (bus.y_in[g] !== ~(a_drv_q[g] & b_drv_q[g]));
      n_mis_c       = n_mis_c + MIS_W'(mismatch_c[g]);
    end
    sum_c            = SUM_W'(fail_count_q) + SUM_W'(n_mis_c);
    fail_count_sat_c = sum_c[CNT_W] ? {CNT_W{1'b1}} : sum_c[CNT_W-1:0];
  end

  // Next-state and run bookkeeping.
  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    pass_cnt_d   = pass_cnt_q;
    fail_mask_d  = fail_mask_q;
    fail_count_d = fail_count_q;
    timer_load_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d      = S_DRIVE;
          v_d          = '0;
          pass_cnt_d   = '0;
          fail_mask_d  = '0;
          fail_count_d = '0;
        end
      end
      S_DRIVE: begin
        if (SETTLE_CYCLES == 0) begin
          state_d = S_CHECK;
        end else begin
          state_d      = S_SETTLE;
          timer_load_c = 1'b1;
        end
      end
      S_SETTLE: begin
        if (timer_zero_c) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        fail_mask_d  = fail_mask_q | mismatch_c;
        fail_count_d = fail_count_sat_c;
        if ((&v_q) && (pass_cnt_q == LAST_PASS)) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_DRIVE;
          v_d     = v_q + VEC_W'(1);
          if (&v_q) begin
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort ends any run immediately; results gathered so far are kept.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      fail_mask_d  = fail_mask_q;
      fail_count_d = fail_count_q;
      timer_load_c = 1'b0;
    end
  end

  // Registered outputs, derived from the current state (abort forces idle view).
  always_comb begin
    out_state_c = bus.abort ? S_IDLE : state_q;
    a_drv_d     = '0;
    b_drv_d     = '0;
    code_c      = '0;
    if ((out_state_c == S_DRIVE) || (out_state_c == S_SETTLE) || (out_state_c == S_CHECK)) begin
      for (int g = 0; g < int'(NUM_GATES); g++) begin
        code_c     = vec_code(v_q, VEC_W'(g));
        a_drv_d[g] = code_c[1];
        b_drv_d[g] = code_c[0];
      end
    end
    busy_d    = (out_state_c != S_IDLE);
    done_d    = (out_state_c == S_FINISH);
    pass_d    = (fail_mask_d == '0);
    vec_idx_d = v_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      v_q          <= '0;
      pass_cnt_q   <= '0;
      fail_mask_q  <= '0;
      fail_count_q <= '0;
      a_drv_q      <= '0;
      b_drv_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b1;
      vec_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_mask_q  <= fail_mask_d;
      fail_count_q <= fail_count_d;
      a_drv_q      <= a_drv_d;
      b_drv_q      <= b_drv_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      vec_idx_q    <= vec_idx_d;
    end
  end

  assign bus.a_drv      = a_drv_q;
  assign bus.b_drv      = b_drv_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_mask  = fail_mask_q;
  assign bus.fail_count = fail_count_q;
  assign bus.vec_idx    = vec_idx_q;

endmodule

// File: tb/tb_nand_test_sequencer.sv
// Bench for nand_test_sequencer: two instances (settle 2 / 1 pass and
// settle 0 / 3 passes) each driving a quad-NAND model with stuck-at faults.
module tb_nand_test_sequencer;

  localparam int S_A = 2;
  localparam int N_A = 1;
  localparam int S_B = 0;
  localparam int N_B = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nand_test_sequencer_if ifa ();
  nand_test_sequencer_if ifb ();

  logic [3:0] sa0_a, sa1_a, sa0_b, sa1_b;

  // Quad-NAND with stuck-at faults (stuck-at-1 dominates).
  function automatic logic [3:0] quad_nand(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] sa0, input logic [3:0] sa1);
    return (~(a & b) & ~sa0) | sa1;
  endfunction

  assign ifa.y_in = quad_nand(ifa.a_drv, ifa.b_drv, sa0_a, sa1_a);
  assign ifb.y_in = quad_nand(ifb.a_drv, ifb.b_drv, sa0_b, sa1_b);

  nand_test_sequencer #(.SETTLE_CYCLES(S_A), .NUM_PASSES(N_A)) u_dut_a (
    .CLK (clk), .RST (rst), .bus (ifa.slave)
  );
  nand_test_sequencer #(.SETTLE_CYCLES(S_B), .NUM_PASSES(N_B)) u_dut_b (
    .CLK (clk), .RST (rst), .bus (ifb.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int which, input logic val);
    if (which == 1) ifb.start = val;
    else            ifa.start = val;
  endtask

  task automatic set_faults(input int which, input logic [3:0] sa0, input logic [3:0] sa1);
    if (which == 1) begin sa0_b = sa0; sa1_b = sa1; end
    else            begin sa0_a = sa0; sa1_a = sa1; end
  endtask

  // {busy, done, a_drv, b_drv, vec_idx}
  function automatic logic [12:0] run_snap(input int which);
    if (which == 1) return {ifb.busy, ifb.done, ifb.a_drv, ifb.b_drv, ifb.vec_idx};
    return {ifa.busy, ifa.done, ifa.a_drv, ifa.b_drv, ifa.vec_idx};
  endfunction

  // {fail_mask, fail_count, pass}
  function automatic logic [12:0] res_snap(input int which);
    if (which == 1) return {ifb.fail_mask, ifb.fail_count, ifb.pass};
    return {ifa.fail_mask, ifa.fail_count, ifa.pass};
  endfunction

  // Reference: outcome of the first nchecks vector checks against the fault model.
  task automatic model_result(input int nchecks, input logic [3:0] sa0, input logic [3:0] sa1,
                              output logic [3:0] mask, output int cnt);
    mask = '0;
    cnt  = 0;
    for (int i = 0; i < nchecks; i++) begin
      for (int g = 0; g < 4; g++) begin
        int  c;
        bit  good, y;
        c    = (i % 4 + g) % 4;
        good = (c == 3) ? 1'b0 : 1'b1;
        y    = sa1[g] ? 1'b1 : (sa0[g] ? 1'b0 : good);
        if (y != good) begin
          mask[g] = 1'b1;
          if (cnt < 255) cnt++;
        end
      end
    end
  endtask

  // Expected drive pattern for vector v: code c = (v+g) mod 4, a = c/2, b = c%2.
  function automatic logic [7:0] exp_drives(input int v);
    logic [3:0] ea, eb;
    for (int g = 0; g < 4; g++) begin
      int c;
      c     = (v + g) % 4;
      ea[g] = 1'(c / 2);
      eb[g] = 1'(c % 2);
    end
    return {ea, eb};
  endfunction

  // One run; accepted on the next posedge. Called #1 after a posedge.
  task automatic run_check(input int which, input int s, input int n,
                           input logic [3:0] sa0, input logic [3:0] sa1,
                           input bit hold, input bit poke);
    int         e, ec, v;
    logic [3:0] em;
    e = 1 + n * 4 * (s + 2);
    model_result(n * 4, sa0, sa1, em, ec);
    set_faults(which, sa0, sa1);
    set_start(which, 1'b1);
    @(posedge clk); #1;
    if (!hold) set_start(which, 1'b0);
    for (int k = 1; k <= e; k++) begin
      @(posedge clk); #1;
      if (poke && !hold) begin
        if (k == 3) set_start(which, 1'b1);
        if (k == 4) set_start(which, 1'b0);
      end
      if (k < e) begin
        v = ((k - 1) / (s + 2)) % 4;
        check_val($sformatf("run%0d_k%0d", which, k), 32'(run_snap(which)),
                  32'({1'b1, 1'b0, exp_drives(v), 2'(v)}));
      end else begin
        check_val($sformatf("run%0d_done", which), 32'(run_snap(which) >> 2), 32'({1'b1, 1'b1, 8'h00}));
        check_val($sformatf("run%0d_result", which), 32'(res_snap(which)),
                  32'({em, 8'(ec), (em == 4'h0)}));
      end
    end
    if (!hold) begin
      @(posedge clk); #1;
      check_val($sformatf("run%0d_after", which), 32'(run_snap(which) >> 11), 32'(2'b00));
      check_val($sformatf("run%0d_held", which), 32'(res_snap(which)),
                32'({em, 8'(ec), (em == 4'h0)}));
    end
  endtask

  localparam logic [25:0] RESET_VAL = {13'h0000, 4'h0, 8'h00, 1'b1};

  initial begin
    logic [3:0] em, r0, r1;
    int         ec, seen;
    rst = 1'b1;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    sa0_a = '0; sa1_a = '0; sa0_b = '0; sa1_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_a", 32'({run_snap(0), res_snap(0)}), 32'(RESET_VAL));
    check_val("reset_b", 32'({run_snap(1), res_snap(1)}), 32'(RESET_VAL));
    rst = 1'b0;
    @(posedge clk); #1;

    // Fault-free, then gate 4 stuck-at-1.
    run_check(0, S_A, N_A, 4'h0, 4'h0, 1'b0, 1'b0);
    run_check(0, S_A, N_A, 4'h0, 4'h8, 1'b0, 1'b0);
    check_val("g4_sa1_mask", 32'(ifa.fail_mask), 32'h8);
    check_val("g4_sa1_count", 32'(ifa.fail_count), 32'd1);

    // No settle, three passes, all Y stuck-at-0.
    run_check(1, S_B, N_B, 4'hF, 4'h0, 1'b0, 1'b0);
    check_val("all_sa0_mask", 32'(ifb.fail_mask), 32'hF);
    check_val("all_sa0_count", 32'(ifb.fail_count), 32'd36);

    // Abort during the settle of vector 2.
    set_faults(0, 4'h1, 4'h0);
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      check_val($sformatf("abort_k%0d", k), 32'(run_snap(0)),
                32'({1'b1, 1'b0, exp_drives((k - 1) / 4), 2'((k - 1) / 4)}));
    end
    ifa.abort = 1'b1;
    @(posedge clk); #1;
    ifa.abort = 1'b0;
    model_result(2, 4'h1, 4'h0, em, ec);
    check_val("abort_outputs", 32'(run_snap(0) >> 2), 32'h0);
    check_val("abort_result", 32'(res_snap(0)), 32'({em, 8'(ec), 1'b0}));
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (ifa.busy || ifa.done) seen++;
    end
    check_val("abort_quiet", 32'(seen), 32'd0);
    check_val("abort_kept", 32'(ifa.fail_mask), 32'(em));
    run_check(0, S_A, N_A, 4'h1, 4'h0, 1'b0, 1'b0);

    // Reset mid-CHECK with start held; restart on the first free edge.
    set_faults(0, 4'h0, 4'h8);
    ifa.start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst_mid_a", 32'({run_snap(0), res_snap(0)}), 32'(RESET_VAL));
    rst = 1'b0;
    run_check(0, S_A, N_A, 4'h0, 4'h8, 1'b0, 1'b0);

    // Start held across back-to-back runs, then start pulsed mid-run.
    run_check(0, S_A, N_A, 4'h2, 4'h0, 1'b1, 1'b0);
    run_check(0, S_A, N_A, 4'h0, 4'h4, 1'b0, 1'b0);
    run_check(1, S_B, N_B, 4'h0, 4'h1, 1'b0, 1'b1);
    run_check(0, S_A, N_A, 4'h0, 4'h0, 1'b0, 1'b1);

    // Random faults on random instance.
    for (int it = 0; it < 8; it++) begin
      int which;
      which = int'($urandom_range(0, 1));
      r1    = 4'($urandom);
      r0    = 4'($urandom) & ~r1;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if (which == 1) run_check(1, S_B, N_B, r0, r1, 1'b0, ($urandom_range(0, 1) == 1));
      else            run_check(0, S_A, N_A, r0, r1, 1'b0, ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
